mest_result_collector: RTL and testbench

MEST_RESULT_COLLECTOR -- requirements
Module: mest_result_collector

---
 rtl/mest_result_collector.sv | 123 ++++++++++++
 tb/tb_mest_result_collector.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mest_result_collector.sv
// Result collector: a first-word-fall-through FIFO for processor results, with running
// count, checksum and a drop flag, plus a phase FSM that reports when the program has drained.
module mest_result_collector #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     i_reset_n,
   input  logic [DATA_W-1:0]        i_result,
   input  logic                     i_valid_result,
   input  logic                     i_carry,
   input  logic                     i_zero_flag,
   input  logic                     i_all_done,
   output logic [DATA_W+1:0]        o_rd_data,
   output logic                     o_rd_valid,
   input  logic                     i_rd_ready,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_overflow,
   output logic [CNT_W-1:0]         o_total,
   output logic [CNT_W-1:0]         o_checksum,
   output logic                     o_done
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

   state_e                state_q, state_d;
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]           count_q, count_d;
   logic                  overflow_q;
   logic [CNT_W-1:0]      total_q, checksum_q;
   logic [DATA_W+1:0]     mem_q [DEPTH];

   logic                  push, pop;

   // Status outputs come straight from registers so no input can glitch them.
   assign o_rd_valid = (count_q != '0);
   assign o_full     = (count_q == FullCnt);
   assign o_count    = count_q;
   assign o_done     = (state_q == StDone);
   assign o_overflow = overflow_q;
   assign o_total    = total_q;
   assign o_checksum = checksum_q;
   assign o_rd_data  = mem_q[rd_ptr_q];

   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign pop  = o_rd_valid && i_rd_ready;
   assign push = i_valid_result && (state_q != StDone) && (!o_full || pop);

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (i_all_done) begin
               state_d = StDrain;
            end else if (push) begin
               state_d = StCollect;
            end
         end
         StCollect: begin
            if (i_all_done) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (count_d == '0) begin
               state_d = StDone;
            end
         end
         StDone: state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         total_q    <= '0;
         checksum_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (push) begin
            wr_ptr_q   <= wr_ptr_q + AW'(1);
            checksum_q <= checksum_q + CNT_W'(i_result);
            if (total_q != '1) begin
               total_q <= total_q + CNT_W'(1);
            end
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (i_valid_result && !push) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Storage needs no reset; entries are only visible once written.
   always_ff @(posedge clk) begin
      if (i_reset_n && push) begin
         mem_q[wr_ptr_q] <= {i_carry, i_zero_flag, i_result};
      end
   end

endmodule

// File: tb/tb_mest_result_collector.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed
// literal checks; a second instance with a 4-bit counter exercises saturation and wrap.
module tb_mest_result_collector;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       i_reset_n = 1'b0;
   logic [7:0] i_result = '0;
   logic       i_valid_result = 1'b0;
   logic       i_carry = 1'b0;
   logic       i_zero_flag = 1'b0;
   logic       i_all_done = 1'b0;
   logic       i_rd_ready = 1'b0;

   logic [9:0]  o_rd_data, d2_rd_data;
   logic        o_rd_valid, d2_rd_valid;
   logic [4:0]  o_count, d2_count;
   logic        o_full, d2_full;
   logic        o_overflow, d2_overflow;
   logic [15:0] o_total, o_checksum;
   logic [3:0]  d2_total, d2_checksum;
   logic        o_done, d2_done;

   int checks = 0;
   int errors = 0;
   bit check_en = 0;

   always #5 clk = ~clk;

   mest_result_collector #(.DEPTH(16), .DATA_W(8), .CNT_W(16)) dut (
      .clk(clk), .i_reset_n(i_reset_n), .i_result(i_result),
      .i_valid_result(i_valid_result), .i_carry(i_carry), .i_zero_flag(i_zero_flag),
      .i_all_done(i_all_done), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
      .i_rd_ready(i_rd_ready), .o_count(o_count), .o_full(o_full),
      .o_overflow(o_overflow), .o_total(o_total), .o_checksum(o_checksum), .o_done(o_done)
   );

   mest_result_collector #(.DEPTH(16), .DATA_W(8), .CNT_W(4)) dut2 (
      .clk(clk), .i_reset_n(i_reset_n), .i_result(i_result),
      .i_valid_result(i_valid_result), .i_carry(i_carry), .i_zero_flag(i_zero_flag),
      .i_all_done(i_all_done), .o_rd_data(d2_rd_data), .o_rd_valid(d2_rd_valid),
      .i_rd_ready(i_rd_ready), .o_count(d2_count), .o_full(d2_full),
      .o_overflow(d2_overflow), .o_total(d2_total), .o_checksum(d2_checksum), .o_done(d2_done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of entries plus a few flags.
   logic [9:0]  m_q [$];
   bit          m_ovf, m_drain, m_done, m_pop, m_push;
   int unsigned m_total;
   logic [31:0] m_sum;

   always @(posedge clk) begin
      if (!i_reset_n) begin
         m_q.delete();
         m_ovf = 0; m_drain = 0; m_done = 0; m_total = 0; m_sum = '0;
      end else begin
         m_pop  = (m_q.size() > 0) && i_rd_ready;
         m_push = i_valid_result && !m_done && ((m_q.size() < DEPTH) || m_pop);
         if (i_valid_result && !m_push) m_ovf = 1;
         if (m_pop) void'(m_q.pop_front());
         if (m_push) begin
            m_q.push_back({i_carry, i_zero_flag, i_result});
            m_total++;
            m_sum = m_sum + 32'(i_result);
         end
         if (m_drain && m_q.size() == 0) m_done = 1;
         if (i_all_done) m_drain = 1;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("rd_valid", 32'(o_rd_valid), 32'(m_q.size() > 0));
         chk("count", 32'(o_count), 32'(m_q.size()));
         chk("full", 32'(o_full), 32'(m_q.size() == DEPTH));
         chk("overflow", 32'(o_overflow), 32'(m_ovf));
         chk("done", 32'(o_done), 32'(m_done));
         chk("total", 32'(o_total), (m_total > 65535) ? 32'd65535 : 32'(m_total));
         chk("checksum", 32'(o_checksum), 32'(m_sum[15:0]));
         chk("d2_total", 32'(d2_total), (m_total > 15) ? 32'd15 : 32'(m_total));
         chk("d2_checksum", 32'(d2_checksum), 32'(m_sum[3:0]));
         chk("d2_count", 32'(d2_count), 32'(m_q.size()));
         if (m_q.size() > 0) begin
            chk("rd_data", 32'(o_rd_data), 32'(m_q[0]));
            chk("d2_rd_data", 32'(d2_rd_data), 32'(m_q[0]));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      i_valid_result = 0; i_all_done = 0; i_rd_ready = 0;
      i_carry = 0; i_zero_flag = 0; i_result = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      i_reset_n = 0;
      cyc();
      i_reset_n = 1;
   endtask

   task automatic strobe(input logic [7:0] v);
      i_valid_result = 1; i_result = v;
      cyc();
      i_valid_result = 0;
   endtask

   initial begin
      do_reset();
      check_en = 1;
      chk("rst_count", 32'(o_count), 32'd0);
      chk("rst_valid", 32'(o_rd_valid), 32'd0);

      // Single result with flags
      i_carry = 1; i_zero_flag = 0;
      strobe(8'h2A);
      i_carry = 0;
      chk("single_data", 32'(o_rd_data), 32'h22A);
      chk("single_valid", 32'(o_rd_valid), 32'd1);
      chk("single_count", 32'(o_count), 32'd1);
      chk("single_total", 32'(o_total), 32'd1);
      chk("single_sum", 32'(o_checksum), 32'h2A);

      // Fill then overflow, then drain in order
      do_reset();
      for (int i = 1; i <= 16; i++) strobe(8'(i));
      strobe(8'h55);
      chk("fill_full", 32'(o_full), 32'd1);
      chk("fill_ovf", 32'(o_overflow), 32'd1);
      chk("fill_total", 32'(o_total), 32'd16);
      chk("fill_sum", 32'(o_checksum), 32'd136);
      chk("fill_head", 32'(o_rd_data), 32'h001);
      i_rd_ready = 1;
      repeat (16) cyc();
      i_rd_ready = 0;
      chk("fill_empty", 32'(o_rd_valid), 32'd0);

      // Full with simultaneous push and pop
      do_reset();
      for (int i = 1; i <= 16; i++) strobe(8'(i + 32));
      i_rd_ready = 1;
      strobe(8'h77);
      i_rd_ready = 0;
      chk("fpp_count", 32'(o_count), 32'd16);
      chk("fpp_ovf", 32'(o_overflow), 32'd0);
      chk("fpp_head", 32'(o_rd_data), 32'h022);

      // Done sequence
      do_reset();
      strobe(8'h03); strobe(8'h04); strobe(8'h05);
      i_all_done = 1;
      cyc();
      i_all_done = 0;
      i_rd_ready = 1;
      cyc(); cyc();
      chk("done_early", 32'(o_done), 32'd0);
      cyc();
      chk("done_set", 32'(o_done), 32'd1);
      i_rd_ready = 0;
      strobe(8'h09);
      chk("done_ovf", 32'(o_overflow), 32'd1);
      chk("done_total", 32'(o_total), 32'd3);

      // Saturation and wrap on the 4-bit counter instance
      do_reset();
      i_rd_ready = 1;
      for (int i = 0; i < 20; i++) strobe(8'hFF);
      cyc();
      i_rd_ready = 0;
      chk("sat_total", 32'(d2_total), 32'd15);
      chk("sat_sum", 32'(d2_checksum), 32'd12);
      chk("sat_ovf", 32'(d2_overflow), 32'd0);
      chk("sat_total16", 32'(o_total), 32'd20);

      // Reset mid-run with a simultaneous push
      do_reset();
      for (int i = 0; i < 5; i++) strobe(8'(i + 100));
      i_valid_result = 1; i_result = 8'hEE; i_rd_ready = 1;
      i_reset_n = 0;
      cyc();
      i_reset_n = 1; idle_inputs();
      chk("mid_count", 32'(o_count), 32'd0);
      chk("mid_valid", 32'(o_rd_valid), 32'd0);
      chk("mid_total", 32'(o_total), 32'd0);
      chk("mid_sum", 32'(o_checksum), 32'd0);
      strobe(8'h01);
      chk("mid_first", 32'(o_rd_data), 32'h001);

      // Randomized episodes with varying push/pop pressure
      for (int ep = 0; ep < 8; ep++) begin
         int vp, rp;
         vp = 20 + int'($urandom_range(0, 70));
         rp = 10 + int'($urandom_range(0, 70));
         do_reset();
         for (int c = 0; c < 300; c++) begin
            i_valid_result = ($urandom_range(0, 99) < vp);
            i_result       = 8'($urandom);
            i_carry        = 1'($urandom);
            i_zero_flag    = 1'($urandom);
            i_rd_ready     = ($urandom_range(0, 99) < rp);
            i_all_done     = (c > 150) && ($urandom_range(0, 99) < 3);
            cyc();
         end
      end
      idle_inputs();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
